mmu_walker: RTL and testbench



---
 rtl/mmu_pkg.sv | 24 ++
 rtl/mmu_walker_if.sv | 14 +
 rtl/mmu_tlb.sv | 58 +++++
 rtl/mmu_walker.sv | 188 ++++++++++++++++++
 tb/tb_mmu_walker.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmu_pkg.sv
// Shared types for the MMU walker: FSM states, decoded PTE fields, VA bit ranges.
package mmu_pkg;

  typedef enum logic [2:0] {IDLE, WALK1, WALK2, DATA, RESP} state_e;

  typedef struct packed {
    logic [19:0] frame;
    logic        u;
    logic        p;
  } pte_t;

  localparam int VPN1_HI     = 31;
  localparam int VPN1_LO     = 22;
  localparam int VPN2_HI     = 21;
  localparam int VPN2_LO     = 12;
  localparam int OFF_HI      = 11;
  localparam int TLB_ENTRIES = 4;

  // PTE slot address: table base (bits [31:13]) plus 8-byte scaled index.
  function automatic logic [31:0] pte_addr(input logic [18:0] tbl, input logic [9:0] idx);
    return {tbl, idx, 3'b000};
  endfunction

endpackage

// File: rtl/mmu_walker_if.sv
// Physical memory bus between the walker (master) and the memory system (slave).
interface mmu_walker_if;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_valid;

  modport master (output mem_address, mem_read, mem_write, mem_wdata,
                  input  mem_rdata, mem_valid);
  modport slave  (input  mem_address, mem_read, mem_write, mem_wdata,
                  output mem_rdata, mem_valid);
endinterface

// File: rtl/mmu_tlb.sv
// 4-entry fully associative translation cache (only built with MMU_TLB_EN).
// Combinational lookup, round-robin fill; flush beats a same-cycle fill.
module mmu_tlb
  import mmu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [19:0] i_lookup_vpn,
  output logic        o_hit,
  output logic [19:0] o_hit_frame,
  output logic        o_hit_u,
  input  logic        i_fill,
  input  logic [19:0] i_fill_vpn,
  input  logic [19:0] i_fill_frame,
  input  logic        i_fill_u,
  input  logic        i_flush
);

  logic [TLB_ENTRIES-1:0] valid_q;
  logic [19:0]            tag_q   [TLB_ENTRIES];
  logic [19:0]            frame_q [TLB_ENTRIES];
  logic [TLB_ENTRIES-1:0] u_q;
  logic [1:0]             rr_q;

  always_comb begin
    o_hit       = 1'b0;
    o_hit_frame = '0;
    o_hit_u     = 1'b0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (valid_q[i] && tag_q[i] == i_lookup_vpn) begin
        o_hit       = 1'b1;
        o_hit_frame = frame_q[i];
        o_hit_u     = u_q[i];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= '0;
      u_q     <= '0;
      rr_q    <= '0;
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        tag_q[i]   <= '0;
        frame_q[i] <= '0;
      end
    end else if (i_flush) begin
      valid_q <= '0;
    end else if (i_fill) begin
      valid_q[rr_q] <= 1'b1;
      tag_q[rr_q]   <= i_fill_vpn;
      frame_q[rr_q] <= i_fill_frame;
      u_q[rr_q]     <= i_fill_u;
      rr_q          <= rr_q + 2'd1;
    end
  end

endmodule

// File: rtl/mmu_walker.sv
// Two-level page-table walker between core and memory; untranslated when paging is off.
// Optional 4-entry TLB when MMU_TLB_EN is defined; all outputs registered.
module mmu_walker
  import mmu_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [31:0]  i_cpu_address,
  input  logic         i_cpu_read,
  input  logic         i_cpu_write,
  input  logic [63:0]  i_cpu_wdata,
  output logic [63:0]  o_cpu_rdata,
  output logic         o_cpu_valid,
  output logic         o_error_not_present,
  output logic         o_error_not_user,
  input  logic         i_paging,
  input  logic         i_is_user,
  input  logic [63:0]  i_page_table_base,
  input  logic         i_tlb_flush,
  mmu_walker_if.master mem
);

  state_e      state_q;
  logic [31:0] va_q;
  logic [63:0] wdata_q;
  logic        write_q;
  logic        user_q;
  logic [19:0] frame_q;
  logic [31:0] mem_address_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [63:0] mem_wdata_q;
  logic [63:0] cpu_rdata_q;
  logic        cpu_valid_q;
  logic        err_np_q;
  logic        err_nu_q;

  logic        strobe;
  pte_t        pte_in;
  logic        tlb_hit;
  logic        tlb_hit_u;
  logic [19:0] tlb_hit_frame;

  assign strobe = mem_read_q || mem_write_q;
  assign pte_in = '{frame: mem.mem_rdata[31:12], u: mem.mem_rdata[1], p: mem.mem_rdata[0]};

`ifdef MMU_TLB_EN
  logic [63:0] base_q;
  logic        flushed_q;
  logic        flush;
  logic        fill;
  logic        tlb_raw_hit;

  assign flush   = i_tlb_flush || (i_page_table_base != base_q);
  assign tlb_hit = tlb_raw_hit && !flush;
  // A flush seen at any point of the walk makes the fetched PTE untrustworthy.
  assign fill    = (state_q == WALK2) && strobe && mem.mem_valid && pte_in.p &&
                   (pte_in.u || !user_q) && !flushed_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      base_q    <= '0;
      flushed_q <= 1'b0;
    end else begin
      base_q <= i_page_table_base;
      if (state_q == IDLE)
        flushed_q <= 1'b0;
      else if (flush)
        flushed_q <= 1'b1;
    end
  end

  mmu_tlb u_tlb (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_lookup_vpn (i_cpu_address[VPN1_HI:VPN2_LO]),
    .o_hit        (tlb_raw_hit),
    .o_hit_frame  (tlb_hit_frame),
    .o_hit_u      (tlb_hit_u),
    .i_fill       (fill),
    .i_fill_vpn   (va_q[VPN1_HI:VPN2_LO]),
    .i_fill_frame (pte_in.frame),
    .i_fill_u     (pte_in.u),
    .i_flush      (flush)
  );
`else
  logic unused_cfg;
  assign tlb_hit       = 1'b0;
  assign tlb_hit_u     = 1'b0;
  assign tlb_hit_frame = '0;
  assign unused_cfg    = ^{i_tlb_flush, i_page_table_base[63:32],
                           i_page_table_base[12:0], va_q[VPN1_HI:VPN1_LO]};
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= IDLE;
      va_q          <= '0;
      wdata_q       <= '0;
      write_q       <= 1'b0;
      user_q        <= 1'b0;
      frame_q       <= '0;
      mem_address_q <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_wdata_q   <= '0;
      cpu_rdata_q   <= '0;
      cpu_valid_q   <= 1'b0;
      err_np_q      <= 1'b0;
      err_nu_q      <= 1'b0;
    end else begin
      cpu_valid_q <= 1'b0;
      err_np_q    <= 1'b0;
      err_nu_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_cpu_read || i_cpu_write) begin
            va_q    <= i_cpu_address;
            wdata_q <= i_cpu_wdata;
            write_q <= i_cpu_write;
            user_q  <= i_is_user;
            if (!i_paging || tlb_hit) begin
              if (i_paging && !tlb_hit_u && i_is_user) begin
                err_nu_q <= 1'b1;
                state_q  <= RESP;
              end else begin
                mem_address_q <= i_paging ? {tlb_hit_frame, i_cpu_address[OFF_HI:0]}
                                          : i_cpu_address;
                mem_read_q    <= !i_cpu_write;
                mem_write_q   <= i_cpu_write;
                mem_wdata_q   <= i_cpu_wdata;
                state_q       <= DATA;
              end
            end else begin
              mem_address_q <= pte_addr(i_page_table_base[31:13], i_cpu_address[VPN1_HI:VPN1_LO]);
              mem_read_q    <= 1'b1;
              state_q       <= WALK1;
            end
          end
        end
        WALK1, WALK2: begin
          if (!strobe) begin
            mem_address_q <= pte_addr(frame_q[19:1], va_q[VPN2_HI:VPN2_LO]);
            mem_read_q    <= 1'b1;
          end else if (mem.mem_valid) begin
            mem_read_q <= 1'b0;
            if (!pte_in.p) begin
              err_np_q <= 1'b1;
              state_q  <= RESP;
            end else if (!pte_in.u && user_q) begin
              err_nu_q <= 1'b1;
              state_q  <= RESP;
            end else begin
              frame_q <= pte_in.frame;
              state_q <= (state_q == WALK1) ? WALK2 : DATA;
            end
          end
        end
        DATA: begin
          if (!strobe) begin
            mem_address_q <= {frame_q, va_q[OFF_HI:0]};
            mem_read_q    <= !write_q;
            mem_write_q   <= write_q;
            mem_wdata_q   <= wdata_q;
          end else if (mem.mem_valid) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            cpu_rdata_q <= mem.mem_rdata;
            cpu_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem.mem_address     = mem_address_q;
  assign mem.mem_read        = mem_read_q;
  assign mem.mem_write       = mem_write_q;
  assign mem.mem_wdata       = mem_wdata_q;
  assign o_cpu_rdata         = cpu_rdata_q;
  assign o_cpu_valid         = cpu_valid_q;
  assign o_error_not_present = err_np_q;
  assign o_error_not_user    = err_nu_q;

endmodule

// File: tb/tb_mmu_walker.sv
// Scoreboard bench for mmu_walker: memory-access and core-response queues checked by monitors.
module tb_mmu_walker;
  import mmu_pkg::*;

  localparam int K_OK = 1;
  localparam int K_NP = 2;
  localparam int K_NU = 4;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [63:0] wdata;
  } mexp_t;

  typedef struct {
    int          kind;
    logic [63:0] data;
  } rexp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_address;
  logic        cpu_read, cpu_write;
  logic [63:0] cpu_wdata;
  logic [63:0] cpu_rdata;
  logic        cpu_valid, err_np, err_nu;
  logic        paging, is_user, tlb_flush;
  logic [63:0] pt_base;

  mmu_walker_if mem_bus ();

  mmu_walker dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_cpu_address       (cpu_address),
    .i_cpu_read          (cpu_read),
    .i_cpu_write         (cpu_write),
    .i_cpu_wdata         (cpu_wdata),
    .o_cpu_rdata         (cpu_rdata),
    .o_cpu_valid         (cpu_valid),
    .o_error_not_present (err_np),
    .o_error_not_user    (err_nu),
    .i_paging            (paging),
    .i_is_user           (is_user),
    .i_page_table_base   (pt_base),
    .i_tlb_flush         (tlb_flush),
    .mem                 (mem_bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          lat    = 1;
  mexp_t       mq[$];
  rexp_t       rq[$];
  logic [63:0] mem_a [logic [31:0]];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic push_mem(input logic [31:0] a, input logic wr, input logic [63:0] wd);
    mexp_t e;
    e.addr = a; e.wr = wr; e.wdata = wd;
    mq.push_back(e);
  endtask

  task automatic push_rsp(input int k, input logic [63:0] d);
    rexp_t r;
    r.kind = k; r.data = d;
    rq.push_back(r);
  endtask

  task automatic push_walk(input logic [31:0] l1, input logic [31:0] l2, input logic [31:0] pa);
    push_mem(l1, 1'b0, 64'h0);
    push_mem(l2, 1'b0, 64'h0);
    push_mem(pa, 1'b0, 64'h0);
  endtask

  // Memory model: checks each new access against the queue, acks after lat cycles.
  initial begin : mem_model
    logic [31:0] a;
    logic        wr;
    mexp_t       e;
    mem_bus.mem_valid = 1'b0;
    mem_bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_bus.mem_read || mem_bus.mem_write) begin
        a  = mem_bus.mem_address;
        wr = mem_bus.mem_write;
        checks++;
        if (mq.size() == 0) begin
          errors++;
          $display("FAIL mem_unexpected addr=%h wr=%0b", a, wr);
        end else begin
          e = mq.pop_front();
          if (e.addr !== a || e.wr !== wr || (e.wr && e.wdata !== mem_bus.mem_wdata)) begin
            errors++;
            $display("FAIL mem_access actual=%h/%0b/%h required=%h/%0b/%h",
                     a, wr, mem_bus.mem_wdata, e.addr, e.wr, e.wdata);
          end
        end
        repeat (lat) @(negedge clk);
        mem_bus.mem_valid = 1'b1;
        mem_bus.mem_rdata = (!wr && mem_a.exists(a)) ? mem_a[a] : 64'h0;
        @(negedge clk);
        mem_bus.mem_valid = 1'b0;
        chk("strobe_drop", {63'h0, mem_bus.mem_read | mem_bus.mem_write}, 64'h0);
      end
    end
  end

  // Response monitor: every completion or fault pulse is matched against the queue.
  always @(negedge clk) begin
    rexp_t r;
    int    k;
    if (!rst && (cpu_valid || err_np || err_nu)) begin
      k = int'({err_nu, err_np, cpu_valid});
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected kind=%0d data=%h", k, cpu_rdata);
      end else begin
        r = rq.pop_front();
        if (k != r.kind || (r.kind == K_OK && cpu_rdata !== r.data)) begin
          errors++;
          $display("FAIL rsp actual=%0d/%h required=%0d/%h", k, cpu_rdata, r.kind, r.data);
        end
      end
    end
  end

  task automatic run_req(input logic [31:0] va, input logic wr, input logic [63:0] wd,
                         input logic user);
    bit done;
    done = 0;
    @(negedge clk);
    cpu_address = va; cpu_wdata = wd; is_user = user;
    cpu_write = wr; cpu_read = !wr;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cpu_valid || err_np || err_nu) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout va=%h", va);
    end
    cpu_read = 1'b0; cpu_write = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin : stim
    bit found;
    rst = 1'b1; cpu_address = '0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_wdata = '0;
    paging = 1'b0; is_user = 1'b0; tlb_flush = 1'b0; pt_base = 64'h0001_0000;

    mem_a[32'h0000_1238] = 64'hDEAD_BEEF_0000_0001;
    mem_a[32'h0001_0008] = 64'h0000_0000_0002_0003;
    mem_a[32'h0002_0010] = 64'h0000_0000_0030_0003;
    mem_a[32'h0030_0010] = 64'hCAFE_F00D_1234_5678;
    mem_a[32'h0001_0010] = 64'h0;
    mem_a[32'h0002_0018] = 64'h0000_0000_0030_0001;
    mem_a[32'h0030_0000] = 64'h0123_4567_89AB_CDEF;
    mem_a[32'h0004_0008] = 64'h0000_0000_0002_0003;

    repeat (3) @(negedge clk);
    chk("rst_mem_address", {32'h0, mem_bus.mem_address}, 64'h0);
    chk("rst_mem_read",  {63'h0, mem_bus.mem_read},  64'h0);
    chk("rst_mem_write", {63'h0, mem_bus.mem_write}, 64'h0);
    chk("rst_mem_wdata", mem_bus.mem_wdata, 64'h0);
    chk("rst_cpu_rdata", cpu_rdata, 64'h0);
    chk("rst_cpu_valid", {63'h0, cpu_valid}, 64'h0);
    chk("rst_err_np",    {63'h0, err_np}, 64'h0);
    chk("rst_err_nu",    {63'h0, err_nu}, 64'h0);
    rst = 1'b0;

    // Untranslated read and write.
    lat = 3;
    push_mem(32'h0000_1238, 1'b0, 64'h0);
    push_rsp(K_OK, 64'hDEAD_BEEF_0000_0001);
    run_req(32'h0000_1238, 1'b0, 64'h0, 1'b0);
    lat = 1;
    push_mem(32'h0000_0100, 1'b1, 64'h1122_3344_5566_7788);
    push_rsp(K_OK, 64'h0);
    run_req(32'h0000_0100, 1'b1, 64'h1122_3344_5566_7788, 1'b1);

    // Reset while the L2 read strobe is up; the late ack must be ignored.
    paging = 1'b1;
    lat = 3;
    push_mem(32'h0001_0008, 1'b0, 64'h0);
    push_mem(32'h0002_0010, 1'b0, 64'h0);
    @(negedge clk);
    cpu_address = 32'h0040_2010; cpu_read = 1'b1; is_user = 1'b0;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_bus.mem_read && mem_bus.mem_address == 32'h0002_0010) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL l2_strobe_timeout");
    end
    rst = 1'b1; cpu_read = 1'b0;
    @(negedge clk);
    chk("midwalk_rst_read", {63'h0, mem_bus.mem_read}, 64'h0);
    chk("midwalk_rst_addr", {32'h0, mem_bus.mem_address}, 64'h0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("late_ack_read", {63'h0, mem_bus.mem_read}, 64'h0);

    // Full walk, then faults.
    lat = 2;
    push_walk(32'h0001_0008, 32'h0002_0010, 32'h0030_0010);
    push_rsp(K_OK, 64'hCAFE_F00D_1234_5678);
    run_req(32'h0040_2010, 1'b0, 64'h0, 1'b1);
    lat = 1;
    push_mem(32'h0001_0010, 1'b0, 64'h0);
    push_rsp(K_NP, 64'h0);
    run_req(32'h0080_2000, 1'b0, 64'h0, 1'b0);
    push_mem(32'h0001_0008, 1'b0, 64'h0);
    push_mem(32'h0002_0018, 1'b0, 64'h0);
    push_rsp(K_NU, 64'h0);
    run_req(32'h0040_3000, 1'b0, 64'h0, 1'b1);
    push_walk(32'h0001_0008, 32'h0002_0018, 32'h0030_0000);
    push_rsp(K_OK, 64'h0123_4567_89AB_CDEF);
    run_req(32'h0040_3000, 1'b0, 64'h0, 1'b0);

    // Repeats: served by the TLB when present, walked otherwise.
`ifdef MMU_TLB_EN
    push_rsp(K_NU, 64'h0);
    run_req(32'h0040_3000, 1'b0, 64'h0, 1'b1);
    push_mem(32'h0030_0010, 1'b0, 64'h0);
    push_rsp(K_OK, 64'hCAFE_F00D_1234_5678);
    run_req(32'h0040_2010, 1'b0, 64'h0, 1'b1);
`else
    push_mem(32'h0001_0008, 1'b0, 64'h0);
    push_mem(32'h0002_0018, 1'b0, 64'h0);
    push_rsp(K_NU, 64'h0);
    run_req(32'h0040_3000, 1'b0, 64'h0, 1'b1);
    push_walk(32'h0001_0008, 32'h0002_0010, 32'h0030_0010);
    push_rsp(K_OK, 64'hCAFE_F00D_1234_5678);
    run_req(32'h0040_2010, 1'b0, 64'h0, 1'b1);
`endif

    @(negedge clk);
    tlb_flush = 1'b1;
    @(negedge clk);
    tlb_flush = 1'b0;
    push_walk(32'h0001_0008, 32'h0002_0010, 32'h0030_0010);
    push_rsp(K_OK, 64'hCAFE_F00D_1234_5678);
    run_req(32'h0040_2010, 1'b0, 64'h0, 1'b1);

    pt_base = 64'h0004_0000;
    push_walk(32'h0004_0008, 32'h0002_0010, 32'h0030_0010);
    push_rsp(K_OK, 64'hCAFE_F00D_1234_5678);
    run_req(32'h0040_2010, 1'b0, 64'h0, 1'b1);

    repeat (5) @(negedge clk);
    chk("mem_queue_left", 64'(mq.size()), 64'h0);
    chk("rsp_queue_left", 64'(rq.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
